axis_to_fifo_packer: RTL and testbench

- Upstream neighbour of the replay engine's fifo-to-AXIS stage.
- Consumes packets as an AXI4-Stream from the pcap memory reader.
- For each packet, writes packed words into the async FIFO: first a header word carrying TUSER, then one word per data beat.
- Packed format, lane i (bits 9i+8..9i) = {marker_bit, byte_i}:
  - Marker bits are all zero on header and non-last words.
  - On the last word, exactly one marker bit is set, at the index of the highest valid byte.

---
 rtl/osnt_replay_pkg.sv | 29 ++
 rtl/axis_to_fifo_packer_if.sv | 24 ++
 rtl/replay_strb_encoder.sv | 33 +++
 rtl/axis_to_fifo_packer.sv | 132 +++++++++++++
 tb/tb_axis_to_fifo_packer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/osnt_replay_pkg.sv
// rtl/osnt_replay_pkg.sv - shared lane format, state encoding and pack helpers for the replay packer/unpacker
package osnt_replay_pkg;

    // One packed lane = {marker_bit, byte}
    localparam int LANE_W = 9;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_t;

    // Packed FIFO width for a D-bit stream: one 9-bit lane per byte
    function automatic int packed_width(input int d);
        return (d / 8) * LANE_W;
    endfunction

    function automatic logic [LANE_W-1:0] pack_lane(input logic marker, input logic [7:0] data_byte);
        return {marker, data_byte};
    endfunction

    function automatic logic [7:0] lane_byte(input logic [LANE_W-1:0] lane);
        return lane[7:0];
    endfunction

    function automatic logic lane_marker(input logic [LANE_W-1:0] lane);
        return lane[LANE_W-1];
    endfunction

endpackage

// File: rtl/axis_to_fifo_packer_if.sv
// rtl/axis_to_fifo_packer_if.sv - AXI4-Stream bundle feeding the packer
// Signals: tdata (DATA_W), tstrb (DATA_W/8), tuser (USER_W), tvalid, tready, tlast.
// master drives the stream (memory reader), slave consumes it (packer).
interface axis_to_fifo_packer_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/replay_strb_encoder.sv
// rtl/replay_strb_encoder.sv - highest-byte marker encoder for last-beat tstrb
// Inputs : tstrb         byte enables of the last beat
// Outputs: marker        one-hot at the highest set tstrb bit (lane 0 when tstrb is zero)
//          noncontig_err tstrb is not a contiguous run starting at bit 0
//          zero_err      tstrb has no bits set
module replay_strb_encoder #(
    parameter int STRB_W = 32
) (
    input  logic [STRB_W-1:0] tstrb,
    output logic [STRB_W-1:0] marker,
    output logic              noncontig_err,
    output logic              zero_err
);
    localparam int IDX_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    logic [IDX_W-1:0] hi_idx;
    logic [STRB_W:0]  mask_wide;

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (tstrb[i]) begin
                hi_idx = IDX_W'(i);
            end
        end
        marker         = '0;
        marker[hi_idx] = 1'b1;
        // One extra bit so a marker in the top lane yields an all-ones mask
        mask_wide      = ({1'b0, marker} << 1) - {{STRB_W{1'b0}}, 1'b1};
        zero_err       = ~|tstrb;
        noncontig_err  = (tstrb != mask_wide[STRB_W-1:0]);
    end
endmodule

// File: rtl/axis_to_fifo_packer.sv
// rtl/axis_to_fifo_packer.sv - packs AXI4-Stream packets into header + data words for the replay FIFO
// Ports: axi_aclk/axi_rst  clock and synchronous active-high reset
//        s_axis            stream input (slave modport)
//        fifo_wr_en/din    registered FIFO write strobe and packed word
//        fifo_full         overflow detection only
//        fifo_prog_full    backpressure
//        pkt_count         completed packets (wraps)
//        err_count         format/overflow errors (saturates)
module axis_to_fifo_packer
    import osnt_replay_pkg::*;
#(
    parameter  int C_S_AXIS_DATA_WIDTH  = 256,
    parameter  int C_S_AXIS_TUSER_WIDTH = 128,
    localparam int C_PACKED_WIDTH       = packed_width(C_S_AXIS_DATA_WIDTH)
) (
    input  logic                      axi_aclk,
    input  logic                      axi_rst,
    axis_to_fifo_packer_if.slave      s_axis,
    output logic                      fifo_wr_en,
    output logic [C_PACKED_WIDTH-1:0] fifo_din,
    input  logic                      fifo_full,
    input  logic                      fifo_prog_full,
    output logic [31:0]               pkt_count,
    output logic [15:0]               err_count
);
    localparam int D      = C_S_AXIS_DATA_WIDTH;
    localparam int U      = C_S_AXIS_TUSER_WIDTH;
    localparam int STRB_W = D / 8;

    state_t                    state_q, state_d;
    logic                      fifo_wr_en_q, fifo_wr_en_d;
    logic [C_PACKED_WIDTH-1:0] fifo_din_q, fifo_din_d;
    logic [31:0]               pkt_count_q, pkt_count_d;
    logic [15:0]               err_count_q, err_count_d;

    logic [STRB_W-1:0]         enc_marker;
    logic                      enc_noncontig;
    logic                      enc_zero;
    logic [STRB_W-1:0]         beat_marker;
    logic [D-1:0]              hdr_bytes;
    logic [C_PACKED_WIDTH-1:0] hdr_word;
    logic [C_PACKED_WIDTH-1:0] beat_word;
    logic                      data_ready;
    logic                      fmt_err;
    logic                      ovf_err;
    logic [16:0]               err_sum;

    replay_strb_encoder #(
        .STRB_W (STRB_W)
    ) u_strb_enc (
        .tstrb         (s_axis.tstrb),
        .marker        (enc_marker),
        .noncontig_err (enc_noncontig),
        .zero_err      (enc_zero)
    );

    // Lane packing for both candidate words; markers only ever appear on a last beat
    always_comb begin
        hdr_bytes           = '0;
        hdr_bytes[U-1:0]    = s_axis.tuser;
        beat_marker         = s_axis.tlast ? enc_marker : '0;
        hdr_word            = '0;
        beat_word           = '0;
        for (int i = 0; i < STRB_W; i++) begin
            hdr_word[LANE_W*i +: LANE_W]  = pack_lane(1'b0, hdr_bytes[8*i +: 8]);
            beat_word[LANE_W*i +: LANE_W] = pack_lane(beat_marker[i], s_axis.tdata[8*i +: 8]);
        end
    end

    // tready is held low during reset so no beat is consumed by a state about to be discarded
    assign data_ready    = !axi_rst && (state_q == DATA) && !fifo_prog_full;
    assign s_axis.tready = data_ready;

    always_comb begin
        state_d      = state_q;
        fifo_wr_en_d = 1'b0;
        fifo_din_d   = fifo_din_q;
        pkt_count_d  = pkt_count_q;
        fmt_err      = 1'b0;
        ovf_err      = fifo_wr_en_q && fifo_full;

        unique case (state_q)
            HDR: begin
                // Header is emitted on tvalid alone; the beat stays on the bus for DATA
                if (s_axis.tvalid && !fifo_prog_full) begin
                    fifo_wr_en_d = 1'b1;
                    fifo_din_d   = hdr_word;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (s_axis.tvalid && data_ready) begin
                    fifo_wr_en_d = 1'b1;
                    fifo_din_d   = beat_word;
                    if (s_axis.tlast) begin
                        fmt_err     = enc_zero || enc_noncontig;
                        pkt_count_d = pkt_count_q + 32'd1;
                        state_d     = HDR;
                    end else begin
                        fmt_err     = (s_axis.tstrb != {STRB_W{1'b1}});
                    end
                end
            end
            default: state_d = HDR;
        endcase

        // Both error sources may fire together; sum first, then saturate
        err_sum     = {1'b0, err_count_q} + {16'd0, ovf_err} + {16'd0, fmt_err};
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            state_q      <= HDR;
            fifo_wr_en_q <= 1'b0;
            fifo_din_q   <= '0;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_din_q   <= fifo_din_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign fifo_wr_en = fifo_wr_en_q;
    assign fifo_din   = fifo_din_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;
endmodule

// File: tb/tb_axis_to_fifo_packer.sv
// tb/tb_axis_to_fifo_packer.sv - directed self-checking bench for axis_to_fifo_packer
module tb_axis_to_fifo_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_wr_en;
    logic [287:0] fifo_din;
    logic         fifo_full;
    logic         fifo_prog_full;
    logic [31:0]  pkt_count;
    logic [15:0]  err_count;

    int n_assert = 0;
    int n_fail   = 0;
    int rdy_cnt;

    axis_to_fifo_packer_if #(.DATA_W(256), .USER_W(128)) s_axis_if ();

    axis_to_fifo_packer #(
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_TUSER_WIDTH (128)
    ) dut (
        .axi_aclk       (clk),
        .axi_rst        (rst),
        .s_axis         (s_axis_if),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_din       (fifo_din),
        .fifo_full      (fifo_full),
        .fifo_prog_full (fifo_prog_full),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [287:0] pk(input logic [255:0] d, input logic [31:0] m);
        logic [287:0] w;
        for (int i = 0; i < 32; i++) w[9*i +: 9] = {m[i], d[8*i +: 8]};
        return w;
    endfunction

    function automatic logic [255:0] mk(input logic [31:0] seed);
        return {8{seed}};
    endfunction

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [255:0] d, input logic [31:0] strb, input logic last);
        s_axis_if.tdata  = d;
        s_axis_if.tstrb  = strb;
        s_axis_if.tlast  = last;
        s_axis_if.tvalid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fifo_full = 1'b0;
        fifo_prog_full = 1'b0;
        s_axis_if.tdata = '0;
        s_axis_if.tstrb = '0;
        s_axis_if.tuser = '0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast = 1'b0;
        cyc();
        cyc();
        // Reset state
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_tready", s_axis_if.tready, 0);
        rst = 1'b0;
        cyc();

        // T1: single-beat packet
        s_axis_if.tuser = 128'hABCD;
        drive(mk(32'h0102_0304), 32'h0000_FFFF, 1'b1);
        #1;
        chk("t1_hdr_tready", s_axis_if.tready, 0);
        cyc();
        chk("t1_hdr_wr", fifo_wr_en, 1);
        chk("t1_hdr_lane0", fifo_din[8:0], 9'h0CD);
        chk("t1_hdr_lane1", fifo_din[17:9], 9'h0AB);
        chk("t1_hdr_word", fifo_din, pk(256'hABCD, 32'h0));
        chk("t1_data_tready", s_axis_if.tready, 1);
        cyc();
        chk("t1_data_wr", fifo_wr_en, 1);
        chk("t1_data_word", fifo_din, pk(mk(32'h0102_0304), 32'h0000_8000));
        chk("t1_pkt", pkt_count, 1);
        chk("t1_err", err_count, 0);
        s_axis_if.tvalid = 1'b0;
        #1;
        chk("t1_idle_tready", s_axis_if.tready, 0);
        cyc();
        chk("t1_idle_wr", fifo_wr_en, 0);

        // T2: 3-beat packet, no stalls
        s_axis_if.tuser = 128'h1234_5678;
        drive(mk(32'h1000_0000), 32'hFFFF_FFFF, 1'b0);
        cyc();
        chk("t2_hdr_wr", fifo_wr_en, 1);
        chk("t2_hdr_word", fifo_din, pk(256'h1234_5678, 32'h0));
        rdy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            drive(mk(32'h1000_0000 + k), 32'hFFFF_FFFF, k == 2);
            #1;
            if (s_axis_if.tready) rdy_cnt++;
            cyc();
            chk("t2_wr", fifo_wr_en, 1);
            chk("t2_word", fifo_din, pk(mk(32'h1000_0000 + k), (k == 2) ? 32'h8000_0000 : 32'h0));
        end
        s_axis_if.tvalid = 1'b0;
        #1;
        if (s_axis_if.tready) rdy_cnt++;
        chk("t2_tready_cycles", rdy_cnt, 3);
        chk("t2_pkt", pkt_count, 2);
        cyc();

        // T3: 4-beat packet, 5-cycle stall after beat 1
        s_axis_if.tuser = 128'h77;
        drive(mk(32'h3000_0000), 32'hFFFF_FFFF, 1'b0);
        cyc();
        chk("t3_hdr_word", fifo_din, pk(256'h77, 32'h0));
        cyc();
        chk("t3_b0_word", fifo_din, pk(mk(32'h3000_0000), 32'h0));
        fifo_prog_full = 1'b1;
        drive(mk(32'h3000_0001), 32'hFFFF_FFFF, 1'b0);
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t3_stall_tready", s_axis_if.tready, 0);
            cyc();
            if (s > 0) chk("t3_stall_wr", fifo_wr_en, 0);
        end
        fifo_prog_full = 1'b0;
        for (int k = 1; k < 4; k++) begin
            drive(mk(32'h3000_0000 + k), 32'hFFFF_FFFF, k == 3);
            cyc();
            chk("t3_wr", fifo_wr_en, 1);
            chk("t3_word", fifo_din, pk(mk(32'h3000_0000 + k), (k == 3) ? 32'h8000_0000 : 32'h0));
        end
        s_axis_if.tvalid = 1'b0;
        cyc();
        chk("t3_after_wr", fifo_wr_en, 0);
        chk("t3_pkt", pkt_count, 3);
        chk("t3_err", err_count, 0);

        // T4: format errors
        s_axis_if.tuser = 128'h5;
        drive(mk(32'h4000_0000), 32'h0000_000F, 1'b0);
        cyc();
        cyc();
        chk("t4_partial_word", fifo_din, pk(mk(32'h4000_0000), 32'h0));
        chk("t4_err1", err_count, 1);
        drive(mk(32'h4000_0001), 32'h0, 1'b1);
        cyc();
        chk("t4_zero_word", fifo_din, pk(mk(32'h4000_0001), 32'h1));
        chk("t4_err2", err_count, 2);
        chk("t4_pkt", pkt_count, 4);
        drive(mk(32'h4000_0002), 32'h0000_0005, 1'b1);
        cyc();
        chk("t4_hdr_wr", fifo_wr_en, 1);
        cyc();
        chk("t4_noncontig_word", fifo_din, pk(mk(32'h4000_0002), 32'h4));
        chk("t4_err3", err_count, 3);
        s_axis_if.tvalid = 1'b0;
        cyc();

        // T5: reset mid-packet
        s_axis_if.tuser = 128'h99;
        drive(mk(32'h5000_0000), 32'hFFFF_FFFF, 1'b0);
        cyc();
        cyc();
        drive(mk(32'h5000_0001), 32'hFFFF_FFFF, 1'b0);
        cyc();
        chk("t5_b1_word", fifo_din, pk(mk(32'h5000_0001), 32'h0));
        drive(mk(32'h5000_0002), 32'hFFFF_FFFF, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_tready", s_axis_if.tready, 0);
        cyc();
        chk("t5_rst_wr", fifo_wr_en, 0);
        chk("t5_rst_pkt", pkt_count, 0);
        chk("t5_rst_err", err_count, 0);
        rst = 1'b0;
        #1;
        chk("t5_hdr_tready", s_axis_if.tready, 0);
        cyc();
        chk("t5_hdr_wr", fifo_wr_en, 1);
        chk("t5_hdr_word", fifo_din, pk(256'h99, 32'h0));
        s_axis_if.tvalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // T6: back-to-back 2-beat packets, overflow on one write
        s_axis_if.tuser = 128'hA1;
        drive(mk(32'h6000_0000), 32'hFFFF_FFFF, 1'b0);
        cyc();
        chk("t6_e1_word", fifo_din, pk(256'hA1, 32'h0));
        drive(mk(32'h6000_0000), 32'hFFFF_FFFF, 1'b0);
        cyc();
        chk("t6_e2_word", fifo_din, pk(mk(32'h6000_0000), 32'h0));
        fifo_full = 1'b1;
        drive(mk(32'h6000_0001), 32'hFFFF_FFFF, 1'b1);
        cyc();
        fifo_full = 1'b0;
        chk("t6_e3_word", fifo_din, pk(mk(32'h6000_0001), 32'h8000_0000));
        chk("t6_ovf_err", err_count, 1);
        s_axis_if.tuser = 128'hB2;
        drive(mk(32'h6100_0000), 32'hFFFF_FFFF, 1'b0);
        #1;
        chk("t6_gap_tready", s_axis_if.tready, 0);
        cyc();
        chk("t6_e4_word", fifo_din, pk(256'hB2, 32'h0));
        cyc();
        chk("t6_e5_word", fifo_din, pk(mk(32'h6100_0000), 32'h0));
        drive(mk(32'h6100_0001), 32'hFFFF_FFFF, 1'b1);
        cyc();
        chk("t6_e6_wr", fifo_wr_en, 1);
        chk("t6_e6_word", fifo_din, pk(mk(32'h6100_0001), 32'h8000_0000));
        chk("t6_pkt", pkt_count, 2);
        chk("t6_err", err_count, 1);
        s_axis_if.tvalid = 1'b0;
        cyc();
        chk("t6_end_wr", fifo_wr_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
